// File: rtl/dcache.sv
// Direct-mapped write-through, no-write-allocate data cache, 4-word lines.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache #(
    parameter int INDEX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic        we,
    input  logic [2:0]  width,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic               done_q, done_d;
    logic               wr_hit_q, wr_hit_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_wstrb_q, mem_wstrb_d;

    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES*4];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         wsel;
    logic               hit;
    logic [31:0]        cur_word;
    logic [31:0]        merged;
    logic [31:0]        st_data;
    logic [3:0]         st_strb;
    logic [31:0]        ld_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [1:0]         nxt_beat;
    logic               stall_c;
    logic               data_wen;
    logic               tag_wen;
    logic [INDEX_W+1:0] data_widx;
    logic [31:0]        data_wval;
    logic               hit_inc;
    logic               miss_inc;

    assign idx      = addr[3+INDEX_W:4];
    assign tag      = addr[31:4+INDEX_W];
    assign wsel     = addr[3:2];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign cur_word = data_q[{idx, wsel}];
    assign nxt_beat = beat_q + 2'd1;

    // Store lane placement: replicate data, strobe the addressed bytes
    always_comb begin
        case (width[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_strb = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = wdata;
            end
        endcase
    end

    // Load select and sign/zero extension from the cached word
    always_comb begin
        ld_byte = cur_word[{addr[1:0], 3'b000} +: 8];
        ld_half = addr[1] ? cur_word[31:16] : cur_word[15:0];
        case (width[1:0])
            2'b00:   ld_data = {{24{ld_byte[7] & ~width[2]}}, ld_byte};
            2'b01:   ld_data = {{16{ld_half[15] & ~width[2]}}, ld_half};
            default: ld_data = cur_word;
        endcase
        rdata = re ? ld_data : 32'h0;
    end

    // Merge a write beat's strobed bytes into the currently cached word
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = mem_wstrb_q[i] ? mem_wdata_q[8*i +: 8]
                                              : cur_word[8*i +: 8];
        end
    end

`ifdef DCACHE_STATS_EN
    logic        refilled_q, refilled_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // Counters; the hit that ends a refill is not counted
    always_comb begin
        refilled_d = refilled_q;
        if (state_q == S_IDLE) refilled_d = 1'b0;
        if (state_q == S_REFILL && mem_ack && beat_q == 2'd3)
            refilled_d = 1'b1;
        hit_cnt_d  = hit_cnt_q + {31'd0, hit_inc & ~refilled_q};
        miss_cnt_d = miss_cnt_q + {31'd0, miss_inc};
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            refilled_q <= 1'b0;
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            refilled_q <= refilled_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

    // Controller: hit/miss decision, refill beats, write-through beat
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        done_d      = done_q;
        wr_hit_d    = wr_hit_q;
        valid_d     = valid_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        stall_c     = 1'b0;
        data_wen    = 1'b0;
        tag_wen     = 1'b0;
        data_widx   = {idx, wsel};
        data_wval   = merged;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (we) begin
                    if (!done_q) begin
                        stall_c     = 1'b1;
                        state_d     = S_WRITE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wdata_d = st_data;
                        mem_wstrb_d = st_strb;
                        wr_hit_d    = hit;
                    end
                end else if (re) begin
                    if (hit) begin
                        hit_inc = 1'b1;
                    end else begin
                        stall_c      = 1'b1;
                        miss_inc     = 1'b1;
                        state_d      = S_REFILL;
                        beat_d       = 2'd0;
                        valid_d[idx] = 1'b0;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = {addr[31:4], 4'b0000};
                        mem_wstrb_d  = 4'b0000;
                    end
                end
            end
            S_REFILL: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    data_wen   = 1'b1;
                    data_widx  = {idx, beat_q};
                    data_wval  = mem_rdata;
                    beat_d     = nxt_beat;
                    mem_addr_d = {addr[31:4], nxt_beat, 2'b00};
                    if (beat_q == 2'd3) begin
                        valid_d[idx] = 1'b1;
                        tag_wen      = 1'b1;
                        state_d      = S_IDLE;
                        mem_req_d    = 1'b0;
                    end
                end
            end
            S_WRITE: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    data_wen  = wr_hit_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stall     = stall_c & rst;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    // Control state; reset abandons any beat in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            beat_q      <= 2'd0;
            done_q      <= 1'b0;
            wr_hit_q    <= 1'b0;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
            wr_hit_q    <= wr_hit_d;
            valid_q     <= valid_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    // Tag and data arrays are never cleared; valid bits gate them
    always_ff @(posedge clk) begin
        if (rst && data_wen) data_q[data_widx] <= data_wval;
        if (rst && tag_wen)  tag_q[idx] <= tag;
    end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and backing data memory. It replaces the single-cycle `datamem` path so the core can use a multi-cycle memory. Load hits return in the same cycle. Misses and all stores raise `stall` to the hazard unit until the access completes.

## Interface
Parameters:
- `INDEX_W`, default 4: index bits; the cache has 2^INDEX_W lines of 4 words (16 B) each.
- Tag width is `32-INDEX_W-4`.
- Address fields: offset = `addr[3:0]`, word select = `addr[3:2]`, index = `addr[3+INDEX_W:4]`.

Ports (one clock `clk`; reset `rst` is synchronous and active-low, so the block resets on a rising `clk` edge while `rst`=0):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-low reset
- `addr`  in  32  byte address (`ALUResultM`)
- `wdata`  in  32  store data (`WriteDataM`)
- `re`  in  1  load request
- `we`  in  1  store request
- `width`  in  3  funct3 encoding: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- `rdata`  out  32  extended load data
- `stall`  out  1  hold stages F/D/E/M
- `mem_req`  out  1  backing-memory request (registered)
- `mem_we`  out  1  1 = write beat
- `mem_addr`  out  32  word-aligned beat address
- `mem_wdata`  out  32  write data, byte-lane aligned
- `mem_wstrb`  out  4  byte enables
- `mem_ack`  in  1  beat accepted / read data valid
- `mem_rdata`  in  32  read data, valid when `mem_ack`=1
- `hit_count`, `miss_count`  out  32 each; present only under `DCACHE_STATS_EN`

## Operation
FSM states:
- **IDLE**
- **REFILL**, which uses a 2-bit beat counter
- **WRITE**

Storage per line: valid bit, tag, 4×32 data. A one-bit `done` flag supports store completion.

Behaviour in IDLE:
- `we`=1 has priority over `re`.
- **Load hit** (valid && tag match): `rdata` comes combinationally from the cache. `stall`=0.
- **Load miss**: `stall`=1. Next state REFILL, beat 0, `mem_req`=1, `mem_we`=0, `mem_addr`={tag,index,beat,2'b00}.
- **Store** with `done`=0: `stall`=1. Next state WRITE, `mem_req`=1, `mem_we`=1.
  - Word store: `mem_wstrb`=1111.
  - Half store: `mem_wstrb`=0011 or 1100 by `addr[1]`.
  - Byte store: `mem_wstrb` one-hot by `addr[1:0]`.
  - `mem_wdata` carries the store data replicated into the lanes.
- **Store** with `done`=1: `stall`=0. `done` clears at the next edge, which is the edge on which the store retires.
- Neither `re` nor `we`: `stall`=0 and `rdata`=0.

REFILL:
- On each `mem_ack`, write `mem_rdata` into word[beat] and increment beat.
- On the ack of beat 3: set valid, write the tag, go to IDLE. The held load then hits.
- `stall`=1 throughout.

WRITE:
- On `mem_ack`, go to IDLE and set `done`=1.
- If the line hit at request time, merge the strobed bytes into the cached word on that same edge.
- No allocation on a store miss.
- `stall`=1 throughout.

Load extension:
- lb/lbu select the byte by `addr[1:0]`; lh/lhu select the half by `addr[1]`.
- lb and lh sign-extend; lbu and lhu zero-extend.
- Misaligned halfword (`addr[0]`=1) or word accesses ignore the low address bits; no trap is raised.

## Timing
Reset (`rst`=0 at an edge):
- State IDLE, all valid bits 0, `done`=0, beat 0, `mem_req`=0, counters 0.
- Data and tag arrays are not cleared.
- `stall` is 0 for the whole cycle that `rst`=0.

Memory handshake:
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_wstrb` stay stable from the assertion of `mem_req` until the edge where `mem_ack`=1 is sampled.
- `mem_ack` may be high in the first cycle of `mem_req`. `mem_ack` is ignored in IDLE.
- `mem_req` drops on the edge after the final ack.

Latency with a zero-wait memory (ack in the first request cycle):
- Load miss: `stall`=1 for 5 cycles (detect + 4 beats). The load hits in cycle 6.
- Store: `stall`=1 for 2 cycles. It retires on the edge ending cycle 3.
- Each extra wait cycle per beat adds 1 stall cycle.

Reset mid-operation: the refill or write is abandoned, `mem_req` is 0 after that edge, and the partially refilled line stays invalid.

The CPU holds `addr`, `re`, `we`, `width` and `wdata` stable while `stall`=1.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Ports `hit_count` and `miss_count` exist.
  - `hit_count` increments on each IDLE load hit that was not preceded by a refill for the same access.
  - `miss_count` increments on entry to REFILL.
  - Stores are not counted.
  - Both counters wrap modulo 2^32.
- `DCACHE_STATS_EN` not defined: the ports and counters are absent, and there are no other differences.

## Test plan
- Reset, then `lw` at 0x100 with zero-wait memory returning 0xA0+beat → `stall` high 5 cycles, `mem_addr` sequence 0x100, 0x104, 0x108, 0x10C, then `rdata`=0xA0; a following `lw` at 0x104 → `rdata`=0xA1 with `stall`=0.
- Line at 0x100 holding 0x80FF_7F01 → `lb` at 0x103 returns 0xFFFF_FF80, `lbu` at 0x103 returns 0x80, `lh` at 0x102 returns 0xFFFF_80FF, `lhu` at 0x100 returns 0x7F01.
- `sb` of 0x55 to cached 0x101 → `mem_wstrb`=0010, `mem_wdata[15:8]`=0x55, stall 2 cycles; a following `lw` at 0x100 hits with byte 1 = 0x55.
- `sw` to uncached 0x200 → one write beat, no refill; the next `lw` at 0x200 misses (`miss_count`+1 under `DCACHE_STATS_EN`).
- Aliasing: `lw` at 0x100, then at 0x100+(16<<INDEX_W), then at 0x100 again → three refills.
- 3-cycle ack latency with `rst` driven 0 during beat 2 → `mem_req`=0 after the edge; after release, `lw` at 0x100 refills from beat 0.
